// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: the default operand width
// and the controller state encoding.
package div_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/sub_stage.sv
// Combinational W-bit trial subtractor.
// It computes a - b as a + ~b + 1. A carry out of 1 means no borrow
// occurred, i.e. a >= b.
module sub_stage #(
    parameter int W = 5
) (
    output logic [W-1:0] o_diff,
    output logic         o_carry_out,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b
);

    // Invert-and-add with carry-in 1, widened by one bit to expose the carry.
    assign {o_carry_out, o_diff} = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider that retires one quotient bit per clock.
// The controller accepts a start in IDLE. It runs WIDTH trial-subtract steps
// in RUN, then pulses done for one cycle in DONE. The quotient, remainder and
// div_by_zero results are loaded on the edge that enters DONE, so they are
// valid in the done cycle. They are held until the next operation completes.
module restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_r;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_rshift;
    logic [WIDTH:0]   w_diff;
    logic             w_carry;
    logic [WIDTH:0]   w_rnext;
    logic [WIDTH-1:0] w_qnext;
    logic             w_last;
    logic             w_div_zero;
    logic             w_unused_rmsb;

    // Shift the next dividend bit into the partial remainder.
    assign w_rshift = {r_r[WIDTH-1:0], r_q[WIDTH-1]};

    sub_stage #(
        .W(WIDTH + 1)
    ) u_sub_stage (
        .o_diff      (w_diff),
        .o_carry_out (w_carry),
        .i_a         (w_rshift),
        .i_b         ({1'b0, r_d})
    );

    // A carry means the trial subtraction fit. In that case keep the
    // difference and record a 1 in the quotient. Otherwise restore.
    assign w_rnext    = w_carry ? w_diff : w_rshift;
    assign w_qnext    = {r_q[WIDTH-2:0], w_carry};
    assign w_last     = (r_count == CW'(1));
    assign w_div_zero = (i_divisor == '0);

    // The top bit of R is always zero because R stays below D. The trial
    // subtraction still runs at WIDTH+1 bits so that R' cannot overflow.
    assign w_unused_rmsb = r_r[WIDTH];

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the busy/done strobes decoded from the state.
    always_comb begin
        w_next_state = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = w_div_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q           <= '0;
            r_d           <= '0;
            r_r           <= '0;
            r_count       <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_div_zero) begin
                            r_quotient    <= '1;
                            r_remainder   <= i_dividend;
                            r_div_by_zero <= 1'b1;
                        end else begin
                            r_q     <= i_dividend;
                            r_d     <= i_divisor;
                            r_r     <= '0;
                            r_count <= CW'(WIDTH);
                        end
                    end
                end
                ST_RUN: begin
                    r_q     <= w_qnext;
                    r_r     <= w_rnext;
                    r_count <= r_count - CW'(1);
                    if (w_last) begin
                        r_quotient    <= w_qnext;
                        r_remainder   <= w_rnext[WIDTH-1:0];
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider. Each accepted operation pushes
// its expected result, latency and busy length to a scoreboard. The results
// come from the bench's own reference model. A monitor pops and compares
// these on every done pulse.
module tb_restoring_divider;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dbz;
        int           doneCycle;
        int           busyCycles;
    } expect_t;

    logic         clk;
    logic         rstN;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         divByZero;

    expect_t      sbQueue[$];
    int           checkCount;
    int           failCount;
    int           cycleCount;
    int           busyCount;

    restoring_divider #(
        .WIDTH(W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (divByZero)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so latencies can be checked in cycles.
    always @(posedge clk) begin
        cycleCount = cycleCount + 1;
    end

    // Single point for every comparison: count it and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Wait (bounded) until the DUT sits in IDLE. The task returns at a falling edge.
    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 50) begin
            checkOutput("idleTimeout", 32'd1, 32'd0);
        end
    endtask

    // Issue one division from IDLE. When tracked, the reference result is queued.
    task automatic applyStimulus(input int a, input int b, input bit track);
        expect_t e;
        waitIdle();
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        if (track) begin
            if (b == 0) begin
                e.quo        = '1;
                e.rem        = W'(a);
                e.dbz        = 1'b1;
                e.doneCycle  = cycleCount + 1;
                e.busyCycles = 0;
            end else begin
                e.quo        = W'(a / b);
                e.rem        = W'(a % b);
                e.dbz        = 1'b0;
                e.doneCycle  = cycleCount + 1 + W;
                e.busyCycles = W;
            end
            sbQueue.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Monitor: measure busy length and score every done pulse.
    initial begin
        expect_t e;
        busyCount = 0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                busyCount = 0;
            end else begin
                if (busy) begin
                    busyCount = busyCount + 1;
                end
                if (done) begin
                    if (sbQueue.size() == 0) begin
                        checkOutput("spuriousDone", 32'd1, 32'd0);
                    end else begin
                        e = sbQueue.pop_front();
                        checkOutput("quotient", 32'(quotient), 32'(e.quo));
                        checkOutput("remainder", 32'(remainder), 32'(e.rem));
                        checkOutput("divByZero", 32'(divByZero), 32'(e.dbz));
                        checkOutput("doneLatency", 32'(cycleCount), 32'(e.doneCycle));
                        checkOutput("busyCycles", 32'(busyCount), 32'(e.busyCycles));
                    end
                    busyCount = 0;
                end
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        checkCount = 0;
        failCount  = 0;
        cycleCount = 0;
        rstN       = 1'b0;
        start      = 1'b0;
        dividend   = '0;
        divisor    = '0;

        repeat (3) @(negedge clk);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstQuotient", 32'(quotient), 32'd0);
        checkOutput("rstRemainder", 32'(remainder), 32'd0);
        checkOutput("rstDivByZero", 32'(divByZero), 32'd0);
        rstN = 1'b1;

        $display("[TB] directed divisions");
        applyStimulus(13, 4, 1'b1);
        applyStimulus(15, 1, 1'b1);
        applyStimulus(3, 7, 1'b1);
        applyStimulus(15, 15, 1'b1);
        applyStimulus(9, 0, 1'b1);
        applyStimulus(8, 2, 1'b1);

        $display("[TB] start ignored while running");
        applyStimulus(12, 5, 1'b1);
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        @(negedge clk);
        dividend = 4'd3;
        divisor  = 4'd0;
        @(negedge clk);
        start    = 1'b0;

        $display("[TB] reset during RUN");
        applyStimulus(13, 4, 1'b0);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortQuotient", 32'(quotient), 32'd0);
        checkOutput("abortRemainder", 32'(remainder), 32'd0);
        checkOutput("abortDivByZero", 32'(divByZero), 32'd0);
        repeat (6) @(negedge clk);
        rstN = 1'b1;
        applyStimulus(6, 3, 1'b1);

        $display("[TB] exhaustive back-to-back sweep");
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                applyStimulus(a, b, 1'b1);
            end
        end

        waitIdle();
        repeat (3) @(negedge clk);
        checkOutput("queueEmpty", 32'(sbQueue.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
